// File: rtl/fnd_scan_anim_driver.sv
// fnd_scan_anim_driver: four-digit multiplexed 7-segment driver with a
// frame-synchronous BCD converter and a rotating-segment animation mode.
//
// Ports:
//   clk        - sole clock, rising edge
//   reset      - synchronous, active-high
//   input_data - 14-bit unsigned value to display, saturated to 9999
//   anim_mode  - 1 selects the rotating-segment animation
//   seg_data   - registered active-low segments {dp,g,f,e,d,c,b,a}
//   an         - registered active-low digit enables, an[0] = rightmost
//
// Optional feature: define FND_DP_BLINK_EN to blink the decimal point of
// digit 2 every BLINK_DIV clocks while in numeric mode.
module fnd_scan_anim_driver #(
    parameter int unsigned SCAN_DIV  = 100_000,
    parameter int unsigned ANIM_DIV  = 10_000_000,
    parameter int unsigned BLINK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] input_data,
    input  logic        anim_mode,
    output logic [7:0]  seg_data,
    output logic [3:0]  an
);

    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned ANIM_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [13:0] MAX_VAL = 14'd9999;

    // Reject divider settings the scan/convert timing cannot honour.
    if (SCAN_DIV < 32 || ANIM_DIV < 1 || BLINK_DIV < 1) begin : g_bad_param
        $error("fnd_scan_anim_driver: illegal divider parameter");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_e;
    typedef enum logic {NUM, ANIM} mode_e;

    // ---------------------------------------------------------------
    // Refresh counter and digit index
    // ---------------------------------------------------------------
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic              scan_tc_c;
    logic              frame_start_c;

    always_comb begin
        scan_tc_c     = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
        frame_start_c = scan_tc_c && (idx_q == 2'd3);
        scan_cnt_d    = scan_tc_c ? '0 : scan_cnt_q + SCAN_W'(1);
        idx_d         = scan_tc_c ? idx_q + 2'd1 : idx_q;
    end

    // ---------------------------------------------------------------
    // Shift-add-3 binary to BCD converter, started once per frame
    // ---------------------------------------------------------------
    bcd_state_e  bcd_state_q, bcd_state_d;
    logic [13:0] bin_q, bin_d;
    logic [15:0] bcd_q, bcd_d;
    logic [15:0] disp_q, disp_d;
    logic [3:0]  iter_q, iter_d;
    logic [11:0] bcd_adj_c;

    // The thousands nibble never reaches 5 for inputs <= 9999, so only the
    // lower three nibbles need the add-3 correction.
    always_comb begin
        bcd_adj_c = bcd_q[11:0];
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        bcd_state_d = bcd_state_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        disp_d      = disp_q;
        iter_d      = iter_q;
        case (bcd_state_q)
            IDLE: begin
                if (frame_start_c) begin
                    bin_d       = (input_data > MAX_VAL) ? MAX_VAL : input_data;
                    bcd_d       = '0;
                    iter_d      = '0;
                    bcd_state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d  = {bcd_q[14:12], bcd_adj_c, bin_q[13]};
                bin_d  = {bin_q[12:0], 1'b0};
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'd13) begin
                    bcd_state_d = DONE;
                end
            end
            DONE: begin
                disp_d      = bcd_q;
                bcd_state_d = IDLE;
            end
            default: bcd_state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Mode FSM and animation position
    // ---------------------------------------------------------------
    mode_e             mode_q, mode_d;
    logic [3:0]        pos_q, pos_d;
    logic [ANIM_W-1:0] step_q, step_d;

    always_comb begin
        mode_d = mode_q;
        pos_d  = pos_q;
        step_d = step_q;
        case (mode_q)
            NUM: begin
                if (anim_mode) begin
                    mode_d = ANIM;
                    pos_d  = '0;
                    step_d = '0;
                end
            end
            ANIM: begin
                if (!anim_mode) begin
                    mode_d = NUM;
                end else if (step_q == ANIM_W'(ANIM_DIV - 1)) begin
                    step_d = '0;
                    pos_d  = (pos_q == 4'd11) ? 4'd0 : pos_q + 4'd1;
                end else begin
                    step_d = step_q + ANIM_W'(1);
                end
            end
            default: mode_d = NUM;
        endcase
    end

    // Owner digit and segment bit index (0=a .. 5=f) for each position.
    logic [1:0] anim_dig_c;
    logic [2:0] anim_seg_c;

    always_comb begin
        anim_dig_c = 2'd3;
        anim_seg_c = 3'd0;
        case (pos_q)
            4'd0:    begin anim_dig_c = 2'd3; anim_seg_c = 3'd0; end
            4'd1:    begin anim_dig_c = 2'd2; anim_seg_c = 3'd0; end
            4'd2:    begin anim_dig_c = 2'd1; anim_seg_c = 3'd0; end
            4'd3:    begin anim_dig_c = 2'd0; anim_seg_c = 3'd0; end
            4'd4:    begin anim_dig_c = 2'd0; anim_seg_c = 3'd1; end
            4'd5:    begin anim_dig_c = 2'd0; anim_seg_c = 3'd2; end
            4'd6:    begin anim_dig_c = 2'd0; anim_seg_c = 3'd3; end
            4'd7:    begin anim_dig_c = 2'd1; anim_seg_c = 3'd3; end
            4'd8:    begin anim_dig_c = 2'd2; anim_seg_c = 3'd3; end
            4'd9:    begin anim_dig_c = 2'd3; anim_seg_c = 3'd3; end
            4'd10:   begin anim_dig_c = 2'd3; anim_seg_c = 3'd4; end
            4'd11:   begin anim_dig_c = 2'd3; anim_seg_c = 3'd5; end
            default: begin anim_dig_c = 2'd3; anim_seg_c = 3'd0; end
        endcase
    end

    // ---------------------------------------------------------------
    // Decimal point (digit 2)
    // ---------------------------------------------------------------
    logic dp_bit_c;

`ifdef FND_DP_BLINK_EN
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BLINK_W-1:0] blink_cnt_q;
    logic               dp_q;

    // dp_q = 0 means lit, so the point starts lit out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q <= '0;
            dp_q        <= 1'b0;
        end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_q <= '0;
            dp_q        <= ~dp_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
        end
    end

    assign dp_bit_c = (mode_q == NUM) ? dp_q : 1'b1;
`else
    assign dp_bit_c = 1'b1;
`endif

    // ---------------------------------------------------------------
    // Output decode
    // ---------------------------------------------------------------
    logic [3:0] digit_c;
    logic [6:0] enc_c;
    logic [7:0] seg_d;
    logic [3:0] an_d;

    always_comb begin
        digit_c = disp_q[3:0];
        case (idx_q)
            2'd0:    digit_c = disp_q[3:0];
            2'd1:    digit_c = disp_q[7:4];
            2'd2:    digit_c = disp_q[11:8];
            2'd3:    digit_c = disp_q[15:12];
            default: digit_c = disp_q[3:0];
        endcase

        enc_c = 7'h7F;
        case (digit_c)
            4'd0:    enc_c = 7'h40;
            4'd1:    enc_c = 7'h79;
            4'd2:    enc_c = 7'h24;
            4'd3:    enc_c = 7'h30;
            4'd4:    enc_c = 7'h19;
            4'd5:    enc_c = 7'h12;
            4'd6:    enc_c = 7'h02;
            4'd7:    enc_c = 7'h78;
            4'd8:    enc_c = 7'h00;
            4'd9:    enc_c = 7'h10;
            default: enc_c = 7'h7F;
        endcase

        an_d = ~(4'b0001 << idx_q);

        if (mode_q == ANIM) begin
            seg_d = (idx_q == anim_dig_c) ? ~(8'b0000_0001 << anim_seg_c) : 8'hFF;
        end else begin
            seg_d = {((idx_q == 2'd2) ? dp_bit_c : 1'b1), enc_c};
        end
    end

    // ---------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            bcd_state_q <= IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            disp_q      <= '0;
            iter_q      <= '0;
            mode_q      <= NUM;
            pos_q       <= '0;
            step_q      <= '0;
            seg_data    <= 8'hFF;
            an          <= 4'hF;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            bcd_state_q <= bcd_state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            disp_q      <= disp_d;
            iter_q      <= iter_d;
            mode_q      <= mode_d;
            pos_q       <= pos_d;
            step_q      <= step_d;
            seg_data    <= seg_d;
            an          <= an_d;
        end
    end

endmodule

// File: tb/tb_fnd_scan_anim_driver.sv
// Directed testbench for fnd_scan_anim_driver (default build, dp blink off).
module tb_fnd_scan_anim_driver;

    localparam int unsigned SCAN_DIV  = 32;
    localparam int unsigned ANIM_DIV  = 64;
    localparam int unsigned BLINK_DIV = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] input_data = '0;
    logic        anim_mode = 1'b0;
    logic [7:0]  seg_data;
    logic [3:0]  an;

    int errors = 0;
    int checks = 0;

    logic [3:0] an_exp [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    always #5 clk = ~clk;

    fnd_scan_anim_driver #(
        .SCAN_DIV (SCAN_DIV),
        .ANIM_DIV (ANIM_DIV),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .input_data(input_data),
        .anim_mode (anim_mode),
        .seg_data  (seg_data),
        .an        (an)
    );

    // Return at the first negedge where an has just become t.
    task automatic wait_an(input logic [3:0] t, output bit ok);
        bit left;
        ok   = 1'b0;
        left = (an !== t);
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (an !== t) left = 1'b1;
            else if (left) ok = 1'b1;
        end
    endtask

    // Capture one full frame, each digit sampled 20 clk into its slot.
    task automatic read_frame(output logic [3:0][7:0] seg, output logic [3:0][3:0] ans,
                              output bit ok);
        wait_an(4'hE, ok);
        for (int d = 0; d < 4; d++) begin
            repeat ((d == 0) ? 20 : 32) @(negedge clk);
            seg[d] = seg_data;
            ans[d] = an;
        end
    endtask

    task automatic test_reset();
        logic [3:0] seq_exp [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (seg_data !== 8'hFF) begin
            errors++;
            $display("FAIL reset_seg: got %h expected ff", seg_data);
        end
        checks++;
        if (an !== 4'hF) begin
            errors++;
            $display("FAIL reset_an: got %h expected f", an);
        end
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (an !== seq_exp[d] || seg_data !== 8'hC0) begin
                errors++;
                $display("FAIL reset_scan_start[%0d]: got an=%h seg=%h expected an=%h seg=c0",
                         d, an, seg_data, seq_exp[d]);
            end
            repeat (31) @(negedge clk);
            checks++;
            if (an !== seq_exp[d]) begin
                errors++;
                $display("FAIL reset_scan_end[%0d]: got an=%h expected %h", d, an, seq_exp[d]);
            end
            @(negedge clk);
        end
        checks++;
        if (an !== 4'hE) begin
            errors++;
            $display("FAIL reset_scan_wrap: got an=%h expected e", an);
        end
    endtask

    task automatic test_number();
        logic [3:0][7:0] seg;
        logic [3:0][3:0] ans;
        logic [7:0] exp [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        bit ok;
        input_data = 14'd1234;
        read_frame(seg, ans, ok);
        read_frame(seg, ans, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL number_timeout: got no frame start expected one");
        end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (seg[d] !== exp[d] || ans[d] !== an_exp[d]) begin
                errors++;
                $display("FAIL number_1234[%0d]: got seg=%h an=%h expected seg=%h an=%h",
                         d, seg[d], ans[d], exp[d], an_exp[d]);
            end
        end
    endtask

    task automatic test_saturate();
        logic [3:0][7:0] seg;
        logic [3:0][3:0] ans;
        bit ok;
        input_data = 14'd12000;
        read_frame(seg, ans, ok);
        read_frame(seg, ans, ok);
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (!ok || seg[d] !== 8'h90 || ans[d] !== an_exp[d]) begin
                errors++;
                $display("FAIL saturate[%0d]: got seg=%h an=%h ok=%0d expected seg=90 an=%h",
                         d, seg[d], ans[d], ok, an_exp[d]);
            end
        end
    endtask

    task automatic test_frame_hold();
        logic [3:0][7:0] seg;
        logic [3:0][3:0] ans;
        logic [7:0] old_exp [4] = '{8'h80, 8'hF8, 8'h82, 8'h92};
        logic [7:0] new_exp [4] = '{8'hF9, 8'hA4, 8'hB0, 8'h99};
        bit ok;
        input_data = 14'd5678;
        read_frame(seg, ans, ok);
        read_frame(seg, ans, ok);
        wait_an(4'hE, ok);
        for (int d = 0; d < 4; d++) begin
            repeat ((d == 0) ? 20 : 32) @(negedge clk);
            if (d == 2) input_data = 14'd4321;
            checks++;
            if (!ok || seg_data !== old_exp[d] || an !== an_exp[d]) begin
                errors++;
                $display("FAIL hold_old[%0d]: got seg=%h an=%h expected seg=%h an=%h",
                         d, seg_data, an, old_exp[d], an_exp[d]);
            end
        end
        read_frame(seg, ans, ok);
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (!ok || seg[d] !== new_exp[d] || ans[d] !== an_exp[d]) begin
                errors++;
                $display("FAIL hold_new[%0d]: got seg=%h an=%h expected seg=%h an=%h",
                         d, seg[d], ans[d], new_exp[d], an_exp[d]);
            end
        end
    endtask

    task automatic test_anim();
        // Offsets in clk from the moment anim_mode rises (an just became B).
        int         at      [7] = '{20, 52, 340, 491, 690, 810, 830};
        logic [3:0] an_e    [7] = '{4'hB, 4'h7, 4'hE, 4'hD, 4'h7, 4'h7, 4'h7};
        logic [7:0] seg_e   [7] = '{8'hFF, 8'hFE, 8'hFB, 8'hF7, 8'hEF, 8'hFE, 8'h99};
        int  m;
        bit  ok;
        wait_an(4'hB, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL anim_sync: got no digit 2 slot expected one");
        end
        anim_mode = 1'b1;
        m = 0;
        for (int k = 0; k < 7; k++) begin
            repeat (at[k] - m) @(negedge clk);
            m = at[k];
            checks++;
            if (an !== an_e[k] || seg_data !== seg_e[k]) begin
                errors++;
                $display("FAIL anim_step[%0d]: got an=%h seg=%h expected an=%h seg=%h",
                         k, an, seg_data, an_e[k], seg_e[k]);
            end
            if (k == 5) anim_mode = 1'b0;
        end
    endtask

    task automatic test_dp_off();
        bit seen_lit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (seg_data[7] !== 1'b1) seen_lit = 1'b1;
        end
        checks++;
        if (seen_lit) begin
            errors++;
            $display("FAIL dp_off: got dp low at least once expected always 1");
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0][7:0] seg;
        logic [3:0][3:0] ans;
        logic [7:0] exp [4] = '{8'h82, 8'hF8, 8'h80, 8'h90};
        bit ok;
        input_data = 14'd9876;
        wait_an(4'hE, ok);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (seg_data !== 8'hFF || an !== 4'hF) begin
            errors++;
            $display("FAIL mid_reset_out: got seg=%h an=%h expected ff f", seg_data, an);
        end
        reset = 1'b0;
        for (int d = 0; d < 4; d++) begin
            repeat ((d == 0) ? 20 : 32) @(negedge clk);
            checks++;
            if (seg_data !== 8'hC0 || an !== an_exp[d]) begin
                errors++;
                $display("FAIL mid_reset_zero[%0d]: got seg=%h an=%h expected seg=c0 an=%h",
                         d, seg_data, an, an_exp[d]);
            end
        end
        read_frame(seg, ans, ok);
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (!ok || seg[d] !== exp[d] || ans[d] !== an_exp[d]) begin
                errors++;
                $display("FAIL mid_reset_next[%0d]: got seg=%h an=%h expected seg=%h an=%h",
                         d, seg[d], ans[d], exp[d], an_exp[d]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_number();
        test_saturate();
        test_frame_hold();
        test_anim();
        test_dp_off();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
